// File: rtl/word_narrower_if.sv
// Word-in / byte-out handshake bundle for word_narrower.
// master drives words and out_ready; slave is the narrower itself.
interface word_narrower_if;
  logic [19:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_idx;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready,
    input  out_byte,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  out_idx
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready,
    output out_byte,
    output out_valid,
    input  out_ready,
    output out_last,
    output out_idx
  );
endinterface

// File: rtl/word_narrower.sv
// Splits a 20-bit word into three bytes (LSB or MSB first).
// Define NARROWER_SKIP_ZERO_EN to emit one byte when word[19:8]==0.
module word_narrower #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            rst,
  word_narrower_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SEND0,
    SEND1,
    SEND2
  } state_t;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] idx;
    logic       last;
  } beat_t;

`ifdef NARROWER_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  state_t      state;
  logic [19:0] word_q;
  logic [7:0]  byte_q;
  logic [1:0]  idx_q;
  logic        last_q;
  logic        valid_q;
  logic        ready_q;

  function automatic logic [1:0] pos(
    input logic [1:0] k
  );
    return MSB_FIRST ? 2'd2 - k : k;
  endfunction

  function automatic logic [7:0] pick(
    input logic [19:0] w,
    input logic [1:0]  i
  );
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      default: return {4'b0000, w[19:16]};
    endcase
  endfunction

  function automatic beat_t beat(
    input logic [19:0] w,
    input logic [1:0]  k
  );
    beat_t r;
    // A word with empty upper bits collapses to its low byte alone
    if (SKIP && (w[19:8] == 12'd0)) begin
      r.b    = w[7:0];
      r.idx  = 2'd0;
      r.last = 1'b1;
    end else begin
      r.idx  = pos(k);
      r.b    = pick(w, r.idx);
      r.last = (k == 2'd2);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && ready_q) begin
            word_q  <= bus.in_word;
            state   <= SEND0;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            {byte_q, idx_q, last_q} <=
              beat(bus.in_word, 2'd0);
          end
        end
        SEND0, SEND1, SEND2: begin
          if (valid_q && bus.out_ready) begin
            if (last_q) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              {byte_q, idx_q, last_q} <= '0;
            end else begin
              state <= (state == SEND0)
                       ? SEND1 : SEND2;
              {byte_q, idx_q, last_q} <=
                beat(word_q,
                     (state == SEND0) ? 2'd1 : 2'd2);
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_byte  = byte_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_word_narrower.sv
// Scoreboard bench for word_narrower: LSB-first and MSB-first
// instances share stimulus; a negedge monitor pops expected bytes.
module tb_word_narrower;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] idx;
    logic       last;
  } beat_t;

`ifdef NARROWER_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  word_narrower_if bus0 ();
  word_narrower_if bus1 ();

  assign bus0.in_word   = in_word;
  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;
  assign bus1.in_word   = in_word;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;

  word_narrower #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  word_narrower #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic       ov [2];
  logic       ir [2];
  logic       ol [2];
  logic [7:0] ob [2];
  logic [1:0] oi [2];

  assign ov[0] = bus0.out_valid;
  assign ir[0] = bus0.in_ready;
  assign ol[0] = bus0.out_last;
  assign ob[0] = bus0.out_byte;
  assign oi[0] = bus0.out_idx;
  assign ov[1] = bus1.out_valid;
  assign ir[1] = bus1.in_ready;
  assign ol[1] = bus1.out_last;
  assign ob[1] = bus1.out_byte;
  assign oi[1] = bus1.out_idx;

  beat_t q0 [$];
  beat_t q1 [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void qpush(int i, beat_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qpop(int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference: byte p is (word / 256^p) mod 256
  function automatic void model(int i, logic [19:0] w,
                                bit msb);
    beat_t e;
    int v;
    int p;
    v = int'(w);
    if (SKIP && (v / 256) == 0) begin
      e.b = v[7:0]; e.idx = 2'd0; e.last = 1'b1;
      qpush(i, e);
    end else begin
      for (int k = 0; k < 3; k++) begin
        int t;
        p = msb ? 2 - k : k;
        t = (v >> (8 * p)) % 256;
        e.b = t[7:0];
        e.idx = p[1:0];
        e.last = (k == 2);
        qpush(i, e);
      end
    end
  endfunction

  bit    acc_p   [2];
  bit    fin_p   [2];
  bit    stall_p [2];
  beat_t held    [2];

  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    for (int i = 0; i < 2; i++) begin
      cur = '{ob[i], oi[i], ol[i]};
      if (rst) begin
        if (i == 0) q0.delete();
        else q1.delete();
        acc_p[i] = 0;
        fin_p[i] = 0;
        stall_p[i] = 0;
      end else begin
        chk($sformatf("ready_excl%0d", i),
            32'(ir[i]), 32'(!ov[i]));
        if (acc_p[i])
          chk($sformatf("latency%0d", i), 32'(ov[i]), 1);
        if (fin_p[i])
          chk($sformatf("reready%0d", i), 32'(ir[i]), 1);
        if (stall_p[i])
          chk($sformatf("hold%0d", i),
              32'(cur), 32'(held[i]));
        if (ov[i] && out_ready) begin
          if (qsize(i) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected%0d: got %0h expected none",
                     i, cur);
          end else begin
            e = qpop(i);
            chk($sformatf("beat%0d", i), 32'(cur), 32'(e));
          end
        end
        if (in_valid && ir[i]) model(i, in_word, i == 1);
        acc_p[i]   = in_valid && ir[i];
        fin_p[i]   = ov[i] && out_ready && ol[i];
        stall_p[i] = ov[i] && !out_ready;
        held[i]    = cur;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(int i, logic [7:0] b,
                            logic [1:0] idx, logic last);
    chk($sformatf("dir_byte%0d", i), 32'(ob[i]), 32'(b));
    chk($sformatf("dir_idx%0d", i), 32'(oi[i]), 32'(idx));
    chk($sformatf("dir_last%0d", i), 32'(ol[i]), 32'(last));
  endtask

  // Returns #1 after the accepting edge
  task automatic send(logic [19:0] w);
    int n;
    n = 0;
    in_word = w;
    in_valid = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      if (ir[0]) break;
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got busy expected in_ready");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (n < 200) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 &&
          !ov[0] && !ov[1]) break;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got pending expected empty");
    end
  endtask

  initial begin
    logic [19:0] w;
    bit acc;
    int n;

    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(ov[i]), 0);
      chk("rst_last", 32'(ol[i]), 0);
      chk("rst_idx", 32'(oi[i]), 0);
      chk("rst_byte", 32'(ob[i]), 0);
      chk("rst_ready", 32'(ir[i]), 1);
    end
    rst = 1'b0;
    step();

    send(20'hABCDE);
    expect_out(0, 8'hDE, 2'd0, 1'b0);
    expect_out(1, 8'h0A, 2'd2, 1'b0);
    step();
    expect_out(0, 8'hBC, 2'd1, 1'b0);
    expect_out(1, 8'hBC, 2'd1, 1'b0);
    step();
    expect_out(0, 8'h0A, 2'd2, 1'b1);
    expect_out(1, 8'hDE, 2'd0, 1'b1);
    step();
    chk("idle_ready", 32'(ir[0]), 1);
    chk("idle_valid", 32'(ov[0]), 0);
    drain();

    send(20'h12345);
    expect_out(1, 8'h01, 2'd2, 1'b0);
    step();
    expect_out(1, 8'h23, 2'd1, 1'b0);
    step();
    expect_out(1, 8'h45, 2'd0, 1'b1);
    drain();

    send(20'h0007F);
    expect_out(0, 8'h7F, 2'd0, SKIP);
    expect_out(1, SKIP ? 8'h7F : 8'h00,
               SKIP ? 2'd0 : 2'd2, SKIP);
    step();
    chk("skip_valid", 32'(ov[0]), 32'(!SKIP));
    drain();

    send(20'hABCDE);
    step();
    chk("bp_idx", 32'(oi[0]), 1);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      expect_out(0, 8'hBC, 2'd1, 1'b0);
    end
    out_ready = 1'b1;
    step();
    expect_out(0, 8'h0A, 2'd2, 1'b1);
    drain();

    send(20'h12345);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid0", 32'(ov[0]), 0);
    chk("mid_rst_valid1", 32'(ov[1]), 0);
    chk("mid_rst_ready", 32'(ir[0]), 1);
    repeat (4) begin
      step();
      chk("mid_rst_quiet", 32'(ov[0]), 0);
    end

    send(20'h00001);
    expect_out(0, 8'h01, 2'd0, SKIP);
    in_word = 20'hFFFFF;
    in_valid = 1'b1;
    n = 0;
    while (!ol[0] && n < 10) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("ign_word_last_idx", 32'(oi[0]),
        SKIP ? 32'd0 : 32'd2);
    drain();

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      step();
      if (acc) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        w = 20'($urandom);
        if ($urandom_range(0, 3) == 0) w[19:8] = '0;
        in_word = w;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc = in_valid && ir[0];
    step();
    if (acc || !in_valid) in_valid = 1'b0;
    else begin
      while (in_valid && n < 300) begin
        @(negedge clk);
        acc = ir[0];
        step();
        if (acc) in_valid = 1'b0;
        n++;
      end
      in_valid = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_narrower.md
WORD_NARROWER -- requirements
Module: word_narrower

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0; 0 = emit bytes least-significant first, 1 = most-significant first.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_word, input, 20, word to be split into bytes.
REQ-005 SHALL have port in_valid, input, 1, in_word is valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word.
REQ-007 SHALL have port out_byte, output, 8, current output byte.
REQ-008 SHALL have port out_valid, output, 1, out_byte is valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_byte.
REQ-010 SHALL have port out_last, output, 1, out_byte is the final byte of the word.
REQ-011 SHALL have port out_idx, output, 2, byte position in the word of out_byte (0 = bits 7:0, 1 = bits 15:8, 2 = bits 19:16).

Function
REQ-012 SHALL capture in_word into an internal 20-bit register on a cycle where in_valid and in_ready are both 1.
REQ-013 SHALL implement the states IDLE, SEND0, SEND1 and SEND2.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL drive out_valid high in every SEND state and low in IDLE.
REQ-016 SHALL define the bytes as follows: byte0 = word[7:0]; byte1 = word[15:8]; byte2 = {4'b0000, word[19:16]}, with the upper 4 bits always zero.
REQ-017 SHALL set the emission order by MSB_FIRST: MSB_FIRST=0 gives byte0, byte1, byte2; MSB_FIRST=1 gives byte2, byte1, byte0.
REQ-018 SHALL, in state SENDk, drive out_byte and out_idx for the k-th byte of the chosen order, with out_last=1 only for the final byte.
REQ-019 SHALL present the first byte valid on the cycle after the accept, i.e. latency of 1 clock.
REQ-020 SHALL advance to the next SEND state, or from the final byte to IDLE, only on a cycle where out_valid and out_ready are both 1.
REQ-021 SHALL hold out_byte, out_idx and out_last stable while out_valid=1 and out_ready=0 (backpressure), for an unlimited number of cycles.
REQ-022 SHALL complete a word after the final byte handshake, return to IDLE, and raise in_ready on the next cycle, so throughput is at most one word per (bytes+1) cycles.
REQ-023 SHALL ignore in_valid and leave the captured word unchanged outside IDLE.
REQ-024 SHALL drive all outputs from registers or from state decode only, with no combinational path from in_word to out_byte.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, force the state to IDLE and the word register to 0, taking priority over any handshake in the same cycle.
REQ-026 SHALL produce the reset output values out_valid=0, out_last=0, out_idx=0, out_byte=0 and in_ready=1 on the cycle after reset.
REQ-027 SHALL, on reset mid-word, discard the remaining bytes without emitting them.

Configuration
REQ-028 SHALL, with macro NARROWER_SKIP_ZERO_EN defined, emit a single byte when the captured word[19:8] == 0: byte0 with out_idx=0 and out_last=1, regardless of MSB_FIRST, then return to IDLE.
REQ-029 SHALL, without NARROWER_SKIP_ZERO_EN, always emit three bytes, including when the upper bits are zero.

Verification
REQ-030 SHALL cover basic LSB-first operation: MSB_FIRST=0, word 20'hABCDE accepted, out_ready held 1 -> bytes DE, BC, 0A on consecutive cycles with idx 0,1,2, out_last on 0A, and in_ready=1 one cycle later.
REQ-031 SHALL cover MSB-first ordering: MSB_FIRST=1, word 20'h12345 -> bytes 01, 23, 45 with idx 2,1,0 and out_last on 45.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles during SEND1 with word 20'hABCDE -> BC is held stable with idx=1 throughout, and 0A follows one cycle after out_ready rises.
REQ-033 SHALL cover skip-zero, with NARROWER_SKIP_ZERO_EN defined: word 20'h0007F -> one byte 7F with out_last=1; without the macro -> 7F, 00, 00.
REQ-034 SHALL cover reset mid-word: rst pulsed in SEND1 -> out_valid=0 on the next cycle, in_ready=1, and no further bytes from that word.
REQ-035 SHALL cover ignored input: in_valid held 1 with word 20'hFFFFF while the block is busy emitting 20'h00001 -> the emitted sequence is unchanged (01, 00, 00).
